// File: rtl/seven_seg_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan_if
// Brief    : Bus between a seven_seg_scan block and the logic that feeds it.
// Revision : 1.0 - initial release
// ============================================================================
interface seven_seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int c_IDX_W = $clog2(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp;
    logic                    load;
    logic [3:0]              digit_out;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   anode;
    logic [c_IDX_W-1:0]      digit_idx;
    logic                    frame_start;

    modport master (
        output value, dp, load,
        input  digit_out, dp_out, anode, digit_idx, frame_start
    );

    modport slave (
        input  value, dp, load,
        output digit_out, dp_out, anode, digit_idx, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scan
// Brief    : Time-multiplexed hex display scanner with tear-free frame update
//            and optional inter-digit blanking gap. Optional leading-zero
//            blanking is enabled by defining SEVEN_SEG_SCAN_LZB_EN.
// Revision : 1.0 - initial release
// ============================================================================
module seven_seg_scan #(
    parameter int NUM_DIGITS       = 4,
    parameter int CLK_DIV          = 100000,
    parameter int GAP_CYCLES       = 0,
    parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    seven_seg_scan_if.slave bus
);

    localparam int c_IDX_W   = $clog2(NUM_DIGITS);
    localparam int c_CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0]    c_SHOW_LAST = c_CNT_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0]    c_GAP_LAST  =
        (GAP_CYCLES > 0) ? c_CNT_W'(GAP_CYCLES - 1) : '0;
    localparam logic [c_IDX_W-1:0]    c_LAST_IDX  = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_ONE       = NUM_DIGITS'(1);
    localparam logic [NUM_DIGITS-1:0] c_ANODE_OFF =
        ANODE_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    typedef enum logic [0:0] {
        SHOW = 1'b0,
        GAP  = 1'b1
    } state_t;

    state_t                  r_state;
    logic                    r_run;
    logic [c_IDX_W-1:0]      r_idx;
    logic [c_CNT_W-1:0]      r_cnt;
    logic [4*NUM_DIGITS-1:0] r_pend_val;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic [4*NUM_DIGITS-1:0] r_disp_val;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [3:0]              r_digit;
    logic                    r_dp;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic                    r_frame;

    state_t                  w_nxt_state;
    logic [c_IDX_W-1:0]      w_nxt_idx;
    logic [c_CNT_W-1:0]      w_nxt_cnt;
    logic                    w_adv;
    logic                    w_wrap;
    logic [4*NUM_DIGITS-1:0] w_disp_val;
    logic [NUM_DIGITS-1:0]   w_disp_dp;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [NUM_DIGITS-1:0]   w_lit;
    logic [3:0]              w_nib;
    logic                    w_dpb;

    // Next-state values describe the cycle the registered outputs will show.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_cnt   = r_cnt + 1'b1;
        w_adv       = 1'b0;
        if (!r_run) begin
            w_nxt_state = SHOW;
            w_nxt_cnt   = '0;
            w_adv       = 1'b1;
        end else if (r_state == SHOW) begin
            if (r_cnt == c_SHOW_LAST) begin
                w_nxt_cnt = '0;
                if (GAP_CYCLES > 0) begin
                    w_nxt_state = GAP;
                end else begin
                    w_adv = 1'b1;
                end
            end
        end else begin
            if (r_cnt == c_GAP_LAST) begin
                w_nxt_cnt   = '0;
                w_nxt_state = SHOW;
                w_adv       = 1'b1;
            end
        end

        if (!r_run) begin
            w_nxt_idx = '0;
        end else if (w_adv) begin
            w_nxt_idx = (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;
        end
    end

    // Display contents only change when the scan wraps back to digit 0.
    assign w_wrap     = w_adv && (w_nxt_idx == '0);
    assign w_disp_val = w_wrap ? r_pend_val : r_disp_val;
    assign w_disp_dp  = w_wrap ? r_pend_dp  : r_disp_dp;
    assign w_nib      = w_disp_val[{w_nxt_idx, 2'b00} +: 4];
    assign w_dpb      = w_disp_dp[w_nxt_idx];
    assign w_onehot   = c_ONE << w_nxt_idx;

`ifdef SEVEN_SEG_SCAN_LZB_EN
    logic [NUM_DIGITS:0]   w_hi_zero;
    logic [NUM_DIGITS-1:0] w_blank;

    // w_hi_zero[i]: nibbles i and above are all zero.
    assign w_hi_zero[NUM_DIGITS] = 1'b1;
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lzb
        assign w_hi_zero[gi] = w_hi_zero[gi+1] && (w_disp_val[4*gi +: 4] == 4'h0);
        if (gi == 0) begin : g_lsd
            assign w_blank[gi] = 1'b0;
        end else begin : g_upper
            assign w_blank[gi] = w_hi_zero[gi] && !w_disp_dp[gi];
        end
    end

    assign w_lit = w_onehot & ~w_blank;
`else
    assign w_lit = w_onehot;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= SHOW;
            r_run      <= 1'b0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_pend_val <= '0;
            r_pend_dp  <= '0;
            r_disp_val <= '0;
            r_disp_dp  <= '0;
            r_digit    <= '0;
            r_dp       <= 1'b0;
            r_anode    <= c_ANODE_OFF;
            r_frame    <= 1'b0;
        end else begin
            r_run      <= 1'b1;
            r_state    <= w_nxt_state;
            r_idx      <= w_nxt_idx;
            r_cnt      <= w_nxt_cnt;
            r_disp_val <= w_disp_val;
            r_disp_dp  <= w_disp_dp;
            r_frame    <= w_wrap;
            if (bus.load) begin
                r_pend_val <= bus.value;
                r_pend_dp  <= bus.dp;
            end
            if (w_nxt_state == SHOW) begin
                r_digit <= w_nib;
                r_dp    <= w_dpb;
                r_anode <= ANODE_ACTIVE_LOW ? ~w_lit : w_lit;
            end else begin
                r_dp    <= 1'b0;
                r_anode <= c_ANODE_OFF;
            end
        end
    end

    assign bus.digit_out   = r_digit;
    assign bus.dp_out      = r_dp;
    assign bus.anode       = r_anode;
    assign bus.digit_idx   = r_idx;
    assign bus.frame_start = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scan
// Brief    : Scoreboard bench for three seven_seg_scan configurations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan;

    localparam int N    = 4;
    localparam int NDUT = 3;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp    = '0;
    logic        load  = 1'b0;

    always #5 clk = ~clk;

    seven_seg_scan_if #(.NUM_DIGITS(N)) if_a ();
    seven_seg_scan_if #(.NUM_DIGITS(N)) if_b ();
    seven_seg_scan_if #(.NUM_DIGITS(N)) if_c ();

    assign if_a.value = value;
    assign if_a.dp    = dp;
    assign if_a.load  = load;
    assign if_b.value = value;
    assign if_b.dp    = dp;
    assign if_b.load  = load;
    assign if_c.value = value;
    assign if_c.dp    = dp;
    assign if_c.load  = load;

    seven_seg_scan #(.NUM_DIGITS(N), .CLK_DIV(4), .GAP_CYCLES(0), .ANODE_ACTIVE_LOW(1'b1))
        u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    seven_seg_scan #(.NUM_DIGITS(N), .CLK_DIV(3), .GAP_CYCLES(2), .ANODE_ACTIVE_LOW(1'b1))
        u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    seven_seg_scan #(.NUM_DIGITS(N), .CLK_DIV(2), .GAP_CYCLES(0), .ANODE_ACTIVE_LOW(1'b0))
        u_dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    // Observed word: {anode, digit_idx, digit_out, dp_out, frame_start}
    logic [11:0] w_obs [NDUT];
    assign w_obs[0] = {if_a.anode, if_a.digit_idx, if_a.digit_out, if_a.dp_out, if_a.frame_start};
    assign w_obs[1] = {if_b.anode, if_b.digit_idx, if_b.digit_out, if_b.dp_out, if_b.frame_start};
    assign w_obs[2] = {if_c.anode, if_c.digit_idx, if_c.digit_out, if_c.dp_out, if_c.frame_start};

    int m_div [NDUT] = '{4, 3, 2};
    int m_gap [NDUT] = '{0, 2, 0};
    bit m_al  [NDUT] = '{1'b1, 1'b1, 1'b0};

    int          m_k    [NDUT];
    logic [19:0] m_pend [NDUT];
    logic [19:0] m_disp [NDUT];
    logic [35:0] exp_q [$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

`ifdef SEVEN_SEG_SCAN_LZB_EN
    function automatic bit lzb_blank(input logic [19:0] v, input int dig);
        bit z;
        z = (dig > 0) && (v[16+dig] == 1'b0);
        for (int j = dig; j < N; j++) begin
            if (v[4*j +: 4] != 4'h0) z = 1'b0;
        end
        return z;
    endfunction
`endif

    // Position-in-frame model: output cycle k maps directly to digit and phase.
    task automatic model_step(input int d, output logic [11:0] e);
        int         p, r, dig, ph;
        logic [3:0] nib, lit;
        logic       dpb, show;
        p    = m_div[d] + m_gap[d];
        r    = m_k[d] % (N * p);
        dig  = r / p;
        ph   = r % p;
        show = (ph < m_div[d]);
        if (r == 0) m_disp[d] = m_pend[d];
        if (load) m_pend[d] = {dp, value};
        m_k[d]++;
        nib = m_disp[d][4*dig +: 4];
        dpb = m_disp[d][16+dig];
        lit = 4'b0001 << dig;
`ifdef SEVEN_SEG_SCAN_LZB_EN
        if (lzb_blank(m_disp[d], dig)) lit = 4'b0000;
`endif
        if (!show) begin
            lit = 4'b0000;
            dpb = 1'b0;
        end
        e = {(m_al[d] ? ~lit : lit), 2'(dig), nib, dpb, (r == 0)};
    endtask

    task automatic check_reset(input string tag);
        for (int d = 0; d < NDUT; d++) begin
            check_eq($sformatf("%s_dut%0d", tag, d), 32'(w_obs[d]),
                     32'({(m_al[d] ? 4'hF : 4'h0), 2'b00, 4'h0, 1'b0, 1'b0}));
        end
    endtask

    task automatic drive(input int ph, input int c);
        load = 1'b0;
        if (ph == 1) begin
            case (c)
                9:  begin value = 16'hA3C5; dp = 4'b0100; load = 1'b1; end
                32: begin value = 16'h1234; dp = 4'b0100; load = 1'b1; end
                50: begin value = 16'h1111; dp = 4'b0000; load = 1'b1; end
                55: begin value = 16'h2222; dp = 4'b0100; load = 1'b1; end
                70: begin value = 16'h0030; dp = 4'b0000; load = 1'b1; end
                95: begin value = 16'h0000; dp = 4'b0000; load = 1'b1; end
                default: ;
            endcase
        end else if ($urandom_range(7) == 0) begin
            value = 16'($urandom);
            dp    = 4'($urandom);
            load  = 1'b1;
        end
    endtask

    task automatic run_phase(input int ph, input int ncyc);
        logic [35:0] e;
        logic [11:0] ed;
        exp_q.delete();
        for (int d = 0; d < NDUT; d++) begin
            m_k[d]    = 0;
            m_pend[d] = '0;
            m_disp[d] = '0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            if (c > 0) begin
                e = exp_q.pop_front();
                for (int d = 0; d < NDUT; d++) begin
                    check_eq($sformatf("p%0d_cyc%0d_dut%0d", ph, c - 1, d),
                             32'(w_obs[d]), 32'(e[12*d +: 12]));
                end
            end
            drive(ph, c);
            e = '0;
            for (int d = 0; d < NDUT; d++) begin
                model_step(d, ed);
                e[12*d +: 12] = ed;
            end
            exp_q.push_back(e);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset("reset_init");
        run_phase(1, 130);
        // Reset asserted between edges, mid-SHOW: outputs must clear at once.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("reset_async");
        repeat (2) @(negedge clk);
        check_reset("reset_hold");
        run_phase(2, 240);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
